// File: rtl/mem_port_arbiter.sv
// Arbitrates the single variable-latency memory port between instruction fetch and MEM-stage data access.
// Optional feature macro STALL_CNT_EN adds a saturating front-end stall cycle counter output.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic              halt_in,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_exmem,
  output logic              stall_front,
  output logic              halted,
  output logic              err
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, HALTED} state_e;

  state_e              state_q, state_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                err_q, err_d;
  logic                post_rst_q;
  logic                done_ok;
  logic                dm_req;

  assign dm_req  = dm_rd | dm_wr;
  // A completion is only accepted after the issue cycle of the outstanding transaction.
  assign done_ok = mem_done & ~mem_en_q;

  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (dm_req) begin
          mem_en_d    = 1'b1;
          mem_wr_d    = dm_wr;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wr ? dm_wdata : '0;
          state_d     = BUSY_D;
        end else if (halt_in) begin
          state_d = HALTED;
        end else if (if_req) begin
          mem_en_d   = 1'b1;
          mem_addr_d = if_addr;
          state_d    = BUSY_I;
        end
      end
      BUSY_D:  if (done_ok) state_d = IDLE;
      BUSY_I:  if (done_ok) state_d = IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
    // The first cycle after reset may still see a completion for an abandoned access.
    if (mem_done && (state_q == IDLE || state_q == HALTED) && !post_rst_q)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      post_rst_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      post_rst_q  <= 1'b0;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign halted    = (state_q == HALTED);

  assign dm_done  = (state_q == BUSY_D) & done_ok;
  assign if_valid = (state_q == BUSY_I) & done_ok;
  assign dm_rdata = dm_done  ? mem_rdata : '0;
  assign if_data  = if_valid ? mem_rdata : '0;

  assign stall_exmem = dm_req & ~dm_done & ~halted;
  assign stall_front = stall_exmem | (if_req & ~if_valid) | halted;

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_front && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; define STALL_CNT_EN to also exercise the stall counter.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst, if_req, dm_rd, dm_wr, halt_in, mem_done;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        mem_en, mem_wr, if_valid, dm_done, stall_exmem, stall_front, halted, err;
  logic [15:0] mem_addr, mem_wdata, if_data, dm_rdata;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0;
  int errors = 0;
  int en_seen;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .halt_in(halt_in), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_valid(if_valid), .if_data(if_data), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .stall_exmem(stall_exmem), .stall_front(stall_front), .halted(halted), .err(err)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; halt_in = 1'b0; mem_done = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = 16'h5A5A;
    nxt; nxt; #1;
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_data", if_data, 16'h0000);
    chk("rst_dm_done", dm_done, 1'b0);
    chk("rst_stall_front", stall_front, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_err", err, 1'b0);

    // Fetch at 0x0010, completion two cycles after issue.
    nxt; rst = 1'b0; if_req = 1'b1; if_addr = 16'h0010; #1;
    chk("f_decide_en", mem_en, 1'b0);
    chk("f_decide_stall", stall_front, 1'b1);
    nxt; #1;
    chk("f_issue_en", mem_en, 1'b1);
    chk("f_issue_wr", mem_wr, 1'b0);
    chk("f_issue_addr", mem_addr, 16'h0010);
    nxt; #1;
    chk("f_wait_en", mem_en, 1'b0);
    chk("f_wait_valid", if_valid, 1'b0);
    nxt; mem_done = 1'b1; mem_rdata = 16'hA5A5; #1;
    chk("f_done_valid", if_valid, 1'b1);
    chk("f_done_data", if_data, 16'hA5A5);
    chk("f_done_stall", stall_front, 1'b0);
    nxt; mem_done = 1'b0; if_req = 1'b0; #1;
    chk("f_after_valid", if_valid, 1'b0);
    chk("f_after_en", mem_en, 1'b0);

    // Data write competes with a fetch: data wins.
    nxt; dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF; if_req = 1'b1; if_addr = 16'h0020; #1;
    chk("w_decide_stall_exmem", stall_exmem, 1'b1);
    chk("w_decide_stall_front", stall_front, 1'b1);
    nxt; #1;
    chk("w_issue_en", mem_en, 1'b1);
    chk("w_issue_wr", mem_wr, 1'b1);
    chk("w_issue_addr", mem_addr, 16'h0100);
    chk("w_issue_wdata", mem_wdata, 16'hBEEF);
    nxt; mem_done = 1'b1; #1;
    chk("w_done", dm_done, 1'b1);
    chk("w_done_stall_exmem", stall_exmem, 1'b0);
    chk("w_done_no_ifvalid", if_valid, 1'b0);
    nxt; dm_wr = 1'b0; mem_done = 1'b0; #1;
    chk("wf_decide_en", mem_en, 1'b0);
    chk("wf_decide_dm_done", dm_done, 1'b0);
    nxt; mem_done = 1'b1; mem_rdata = 16'h7777; #1;
    chk("wf_issue_en", mem_en, 1'b1);
    chk("wf_issue_wr", mem_wr, 1'b0);
    chk("wf_issue_addr", mem_addr, 16'h0020);
    chk("wf_issue_done_ignored", if_valid, 1'b0);
    nxt; mem_rdata = 16'h1111; #1;
    chk("wf_done_valid", if_valid, 1'b1);
    chk("wf_done_data", if_data, 16'h1111);
    nxt; mem_done = 1'b0; if_req = 1'b0; #1;
    chk("wf_no_err", err, 1'b0);

    // Data read with completion five cycles after issue.
    nxt; dm_rd = 1'b1; dm_addr = 16'h0200; #1;
    chk("r_decide_stall", stall_exmem, 1'b1);
    nxt; #1;
    chk("r_issue_en", mem_en, 1'b1);
    chk("r_issue_wr", mem_wr, 1'b0);
    chk("r_issue_addr", mem_addr, 16'h0200);
    en_seen = 0;
    for (int i = 0; i < 4; i++) begin
      nxt; #1;
      if (mem_en) en_seen++;
      chk("r_wait_stall", stall_exmem, 1'b1);
    end
    chk("r_single_issue", en_seen, 0);
    nxt; mem_done = 1'b1; mem_rdata = 16'h1234; #1;
    chk("r_done", dm_done, 1'b1);
    chk("r_rdata", dm_rdata, 16'h1234);
    chk("r_done_stall", stall_exmem, 1'b0);
    nxt; dm_rd = 1'b0; mem_done = 1'b0; #1;
    chk("r_after_en", mem_en, 1'b0);

    // Halt beats a pending fetch and is absorbing.
    nxt; halt_in = 1'b1; if_req = 1'b1; if_addr = 16'h0030; #1;
    chk("h_decide_halted", halted, 1'b0);
    nxt; #1;
    chk("h_halted", halted, 1'b1);
    chk("h_stall_front", stall_front, 1'b1);
    chk("h_stall_exmem", stall_exmem, 1'b0);
    en_seen = 0;
    for (int i = 0; i < 20; i++) begin
      nxt; #1;
      if (mem_en) en_seen++;
    end
    chk("h_no_issue", en_seen, 0);
    chk("h_still_halted", halted, 1'b1);
    nxt; rst = 1'b1; halt_in = 1'b0; if_req = 1'b0;
    nxt; #1;
    chk("h_rst_halted", halted, 1'b0);
    chk("h_rst_en", mem_en, 1'b0);

    // Completion in the first post-reset cycle is tolerated; a later stray one is sticky.
    rst = 1'b0; mem_done = 1'b1; #1;
    nxt; #1;
    chk("e_postrst_no_err", err, 1'b0);
    nxt; mem_done = 1'b0; #1;
    chk("e_err_set", err, 1'b1);
    nxt; nxt; #1;
    chk("e_err_sticky", err, 1'b1);

    // Reset while a data read is outstanding.
    dm_rd = 1'b1; dm_addr = 16'h0300;
    nxt; #1;
    chk("a_issue_en", mem_en, 1'b1);
    rst = 1'b1;
    nxt; rst = 1'b0; dm_rd = 1'b0; mem_done = 1'b1; #1;
    chk("a_no_dm_done", dm_done, 1'b0);
    chk("a_idle_en", mem_en, 1'b0);
    chk("a_err_cleared", err, 1'b0);
    nxt; mem_done = 1'b0; #1;
    chk("a_late_done_no_err", err, 1'b0);
    chk("a_still_no_dm_done", dm_done, 1'b0);

`ifdef STALL_CNT_EN
    nxt; rst = 1'b1;
    nxt; rst = 1'b0; if_req = 1'b1; if_addr = 16'h0040; #1;
    chk("c_rst_zero", stall_cnt, 16'h0000);
    repeat (6) nxt;
    nxt; mem_done = 1'b1;
    nxt; mem_done = 1'b0; if_req = 1'b0; #1;
    chk("c_seven", stall_cnt, 16'h0007);
    halt_in = 1'b1;
    repeat (70000) nxt;
    #1;
    chk("c_saturate", stall_cnt, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
